// File: rtl/test_pkg.sv
`default_nettype none
// ============================================================================
// Module      : test_pkg
// Description : Shared types and constants for the response unloader slice.
// Revision    : 1.0 - initial release
// ============================================================================
package test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_DONE    = 3'd4
    } resp_state_t;

    localparam logic [15:0] DEF_MISR_POLY = 16'h1021;
    localparam int          SETTLE_W      = 8;

endpackage
`default_nettype wire

// File: rtl/resp_misr.sv
`default_nettype none
// ============================================================================
// Module      : resp_misr
// Description : Multiple-input signature register; clr has priority over en.
// Revision    : 1.0 - initial release
// ============================================================================
module resp_misr
    import test_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_MISR_POLY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] sig
);

    logic [WIDTH-1:0] r_sig;
    logic [WIDTH-1:0] w_feedback;
    logic [WIDTH-1:0] w_next;

    assign w_feedback = r_sig[WIDTH-1] ? POLY : '0;
    assign w_next     = {r_sig[WIDTH-2:0], 1'b0} ^ w_feedback ^ d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig <= '0;
        end else if (clr) begin
            r_sig <= '0;
        end else if (en) begin
            r_sig <= w_next;
        end
    end

    assign sig = r_sig;

endmodule
`default_nettype wire

// File: rtl/resp_unloader.sv
`default_nettype none
// ============================================================================
// Module      : resp_unloader
// Description : Waits for the netlist to settle, captures the response,
//               streams it LSB-first and folds it into a MISR signature.
// Revision    : 1.0 - initial release
// ============================================================================
module resp_unloader
    import test_pkg::*;
#(
    parameter int               WIDTH  = 16,
    parameter int               SETTLE = 4,
    parameter logic [WIDTH-1:0] POLY   = WIDTH'(DEF_MISR_POLY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pat_valid,
    output logic             pat_ready,
    input  logic [WIDTH-1:0] resp_in,
    output logic             so,
    output logic             so_valid,
    input  logic             so_ready,
    input  logic             sig_clr,
    output logic [WIDTH-1:0] sig,
    output logic             done
);

    localparam int                 c_bit_w       = $clog2(WIDTH);
    localparam logic [c_bit_w-1:0] c_last_bit    = c_bit_w'(WIDTH - 1);
    localparam logic [SETTLE_W-1:0] c_settle_init = SETTLE_W'(SETTLE);

    resp_state_t         r_state;
    resp_state_t         w_state_nxt;
    logic [SETTLE_W-1:0] r_settle_cnt;
    logic [WIDTH-1:0]    r_shift;
    logic [c_bit_w-1:0]  r_bit_cnt;
    logic                w_beat;

    assign w_beat = (r_state == ST_SHIFT) && so_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (pat_valid) begin
                    w_state_nxt = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_settle_cnt == SETTLE_W'(1)) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: w_state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                if (w_beat && (r_bit_cnt == c_last_bit)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: resp_in only matters in CAPTURE, so settling glitches never reach the shifter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_settle_cnt <= '0;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (pat_valid) begin
                        r_settle_cnt <= c_settle_init;
                    end
                end
                ST_SETTLE: r_settle_cnt <= r_settle_cnt - SETTLE_W'(1);
                ST_CAPTURE: begin
                    r_shift   <= resp_in;
                    r_bit_cnt <= '0;
                end
                ST_SHIFT: begin
                    if (w_beat) begin
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= r_bit_cnt + c_bit_w'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    resp_misr #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_misr (
        .clk (clk),
        .rst (rst),
        .en  (r_state == ST_CAPTURE),
        .clr (sig_clr),
        .d   (resp_in),
        .sig (sig)
    );

    assign pat_ready = (r_state == ST_IDLE);
    assign so_valid  = (r_state == ST_SHIFT);
    assign done      = (r_state == ST_DONE);
    assign so        = r_shift[0];

endmodule
`default_nettype wire

// File: tb/tb_resp_unloader.sv
`default_nettype none
// ============================================================================
// Module      : tb_resp_unloader
// Description : Self-checking bench for resp_unloader (SETTLE=4 and SETTLE=0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_resp_unloader;

    localparam int          W      = 16;
    localparam logic [15:0] c_poly = 16'h1021;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pv4 = 1'b0;
    logic         pv0 = 1'b0;
    logic [W-1:0] resp_in = '0;
    logic         so_ready = 1'b1;
    logic         sig_clr = 1'b0;

    logic         pr4, so4, sv4, dn4;
    logic         pr0, so0, sv0, dn0;
    logic [W-1:0] sig4, sig0;

    int           n_cmp = 0;
    int           n_err = 0;
    int           sel = 0;
    logic [W-1:0] sig_m [2];

    logic         m_pr, m_so, m_sv, m_dn;
    logic [W-1:0] m_sig;

    resp_unloader #(.WIDTH(W), .SETTLE(4)) dut4 (
        .clk(clk), .rst(rst), .pat_valid(pv4), .pat_ready(pr4), .resp_in(resp_in),
        .so(so4), .so_valid(sv4), .so_ready(so_ready), .sig_clr(sig_clr),
        .sig(sig4), .done(dn4)
    );

    resp_unloader #(.WIDTH(W), .SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .pat_valid(pv0), .pat_ready(pr0), .resp_in(resp_in),
        .so(so0), .so_valid(sv0), .so_ready(so_ready), .sig_clr(sig_clr),
        .sig(sig0), .done(dn0)
    );

    assign m_pr  = (sel == 1) ? pr0  : pr4;
    assign m_so  = (sel == 1) ? so0  : so4;
    assign m_sv  = (sel == 1) ? sv0  : sv4;
    assign m_dn  = (sel == 1) ? dn0  : dn4;
    assign m_sig = (sel == 1) ? sig0 : sig4;

    always #5 clk = ~clk;

    // Signature as polynomial arithmetic: multiply by x modulo (x^W + POLY), then add the response.
    function automatic logic [W-1:0] misr_next(input logic [W-1:0] s, input logic [W-1:0] d);
        logic [W:0] t;
        t = {1'b0, s} << 1;
        if (t[W]) t = t ^ {1'b1, c_poly};
        return t[W-1:0] ^ d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One pattern on the selected DUT. resp_in switches from early to late at T+5.
    task automatic run_unload(input int s_dut, input logic [W-1:0] early, input logic [W-1:0] late,
                              input int stall_bit, input int stall_len, input bit clr_cap,
                              input int abort_bit);
        int           s_cyc;
        int           cap_k;
        int           first_k;
        int           done_k;
        int           sent;
        int           rem;
        logic         rdy;
        logic [W-1:0] cap;
        s_cyc   = (s_dut == 1) ? 0 : 4;
        cap_k   = 1 + s_cyc;
        first_k = 2 + s_cyc;
        done_k  = s_cyc + W + stall_len + 2;
        sent    = 0;
        rem     = stall_len;
        cap     = (cap_k >= 5) ? late : early;
        sel     = s_dut;
        for (int k = 0; k <= done_k + 1; k++) begin
            @(negedge clk);
            if (abort_bit >= 0 && k == first_k + abort_bit) begin
                rst = 1'b1;
                #1;
                chk("abort_so_valid", 32'(m_sv), 32'd0);
                chk("abort_sig", 32'(m_sig), 32'd0);
                chk("abort_done", 32'(m_dn), 32'd0);
                sig_m[0] = '0;
                sig_m[1] = '0;
                pv4 = 1'b0;
                pv0 = 1'b0;
                sig_clr = 1'b0;
                so_ready = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (k == 0) begin
                chk("pat_ready_idle", 32'(m_pr), 32'd1);
            end else if (k <= done_k) begin
                chk("so_valid", 32'(m_sv), 32'(k >= first_k && k < done_k));
                chk("done", 32'(m_dn), 32'(k == done_k));
                chk("pat_ready_busy", 32'(m_pr), 32'd0);
                if (k == first_k) chk("sig_after_capture", 32'(m_sig), 32'(sig_m[s_dut]));
                if (k >= first_k && k < done_k) chk($sformatf("so_bit%0d", sent), 32'(m_so), 32'(cap[sent]));
            end else begin
                chk("pat_ready_back", 32'(m_pr), 32'd1);
                chk("done_end", 32'(m_dn), 32'd0);
                chk("sig_end", 32'(m_sig), 32'(sig_m[s_dut]));
            end
            if (k == cap_k) begin
                if (clr_cap) begin
                    sig_m[0] = '0;
                    sig_m[1] = '0;
                end else begin
                    sig_m[s_dut] = misr_next(sig_m[s_dut], cap);
                end
            end
            resp_in = (k >= 5) ? late : early;
            if (s_dut == 1) pv0 = (k == 0);
            else            pv4 = (k == 0);
            sig_clr = clr_cap && (k == cap_k);
            rdy = 1'b1;
            if (k >= first_k && k < done_k) begin
                if (sent == stall_bit && rem > 0) begin
                    rdy = 1'b0;
                    rem--;
                end else begin
                    sent++;
                end
            end
            so_ready = rdy;
        end
    endtask

    initial begin
        logic [W-1:0] a, b;
        sig_m[0] = '0;
        sig_m[1] = '0;

        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sel = d;
            #1;
            chk("rst_pat_ready", 32'(m_pr), 32'd1);
            chk("rst_so_valid", 32'(m_sv), 32'd0);
            chk("rst_so", 32'(m_so), 32'd0);
            chk("rst_done", 32'(m_dn), 32'd0);
            chk("rst_sig", 32'(m_sig), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Basic unload and MISR chaining
        run_unload(0, 16'hA5A5, 16'hA5A5, -1, 0, 1'b0, -1);
        chk("basic_sig", 32'(sig4), 32'h0000A5A5);
        run_unload(0, 16'h0001, 16'h0001, -1, 0, 1'b0, -1);
        chk("chain_sig", 32'(sig4), 32'h00005B6A);

        // Backpressure on bit 5 for 3 cycles
        a = W'($urandom);
        run_unload(0, a, a, 5, 3, 1'b0, -1);

        // Settle boundary on both settle lengths
        run_unload(0, 16'h0000, 16'hFFFF, -1, 0, 1'b0, -1);
        run_unload(1, 16'h0000, 16'hFFFF, -1, 0, 1'b0, -1);

        // Clear colliding with capture
        a = W'($urandom);
        run_unload(0, a, a, -1, 0, 1'b1, -1);
        chk("clr_sig", 32'(sig4), 32'd0);

        // Reset mid-shift, then a clean unload
        a = W'($urandom);
        run_unload(0, a, a, -1, 0, 1'b0, 7);
        sel = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_done", 32'(dn4), 32'd0);
            chk("post_rst_ready", 32'(pr4), 32'd1);
        end
        a = W'($urandom);
        run_unload(0, a, a, -1, 0, 1'b0, -1);

        // Randomised patterns and stalls on both instances
        for (int r = 0; r < 8; r++) begin
            a = W'($urandom);
            b = W'($urandom);
            run_unload(int'($urandom_range(0, 1)), a, b, int'($urandom_range(0, W - 1)),
                       int'($urandom_range(0, 4)), 1'b0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/resp_unloader.md
# resp_unloader

Test-side response reader for the gate-level fault-simulation flow. The pattern loader drives a vector onto the mapped netlist's primary inputs through the pin primitives. This block is the other end of that interface: it waits a programmable settle time for the zero/nonzero tphl/tplh gate delays to resolve, then captures the WIDTH-bit response from the pout side. It streams the response serially to the tester over a valid/ready handshake and folds each captured response into a MISR signature.

## Interface
Parameters:
- WIDTH, 16: response width in bits; must be at least 2.
- SETTLE, 4: settle cycles between pattern acceptance and capture; legal range 0..255.
- POLY, 16'h1021: MISR feedback polynomial, WIDTH bits.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- pat_valid  in  1  loader has applied a pattern.
- pat_ready  out  1  block can accept a pattern.
- resp_in  in  WIDTH  circuit response from the pout primitives.
- so  out  1  serial response bit, LSB first.
- so_valid  out  1  so is valid.
- so_ready  in  1  tester accepts so.
- sig_clr  in  1  synchronous clear of the signature.
- sig  out  WIDTH  MISR signature.
- done  out  1  one-cycle pulse at the end of each unload.

## Operation
States are IDLE, SETTLE, CAPTURE, SHIFT and DONE.
- IDLE
  - pat_ready=1.
  - pat_valid=1 is a handshake.
  - On handshake: if SETTLE>0, load the settle counter with SETTLE and go to SETTLE; if SETTLE=0, go to CAPTURE.
- SETTLE
  - Counter decrements each cycle.
  - Go to CAPTURE in the cycle the counter equals 1.
  - resp_in is ignored in this state.
- CAPTURE
  - shift_reg <= resp_in.
  - sig <= ({sig[WIDTH-2:0],1'b0} ^ (sig[WIDTH-1] ? POLY : 0)) ^ resp_in.
  - bit_cnt <= 0; go to SHIFT.
- SHIFT
  - so_valid=1 and so=shift_reg[0].
  - On so_valid&so_ready: shift_reg shifts right and bit_cnt increments.
  - The handshake with bit_cnt=WIDTH-1 goes to DONE.
  - With so_ready=0, so and so_valid hold indefinitely and are stable.
- DONE: done=1 for this single cycle, then go to IDLE.
- sig_clr:
  - Accepted in any state.
  - sig <= 0 and beats a simultaneous CAPTURE update; that response is not folded in.
- pat_valid outside IDLE is ignored. The loader must hold its pattern until pat_ready returns.

## Timing
- Reset values: state=IDLE, pat_ready=1, so_valid=0, so=0, done=0, sig=0, counters=0.
- Reset mid-operation aborts immediately (asynchronous): so_valid drops, done is not pulsed, sig is cleared.
- All outputs are registered or decoded from the state register only. There is no combinational path from so_ready or pat_valid to any output.
- Pattern handshake at cycle T with SETTLE=4:
  - SETTLE occupies T+1..T+4.
  - CAPTURE at T+5 samples resp_in.
  - First so_valid at T+6.
  - With so_ready tied high, bits stream over T+6..T+21.
  - done at T+22; pat_ready=1 at T+23.
- SETTLE=0: CAPTURE at T+1 and first bit at T+2.
- Total latency in cycles = 1 + SETTLE + 1 + WIDTH + (so_ready stall cycles) + 1.

## Structure
- Shared package `test_pkg` holds:
  - the state enum `resp_state_t`;
  - `DEF_MISR_POLY` = 16'h1021;
  - the settle counter width, `SETTLE_W` = 8.
- Sub-module `resp_misr` holds the signature register and its update. Its ports are clk, rst, en, clr, d and sig; clr has priority over en.
- The top level holds the FSM, the settle counter, the shift register and the bit counter.

## Test plan
- Basic unload:
  - Stimulus: reset, SETTLE=4, pat_valid at T, resp_in=16'hA5A5 held, so_ready=1.
  - Required: so sequence 1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1 over T+6..T+21; done at T+22; sig=16'hA5A5.
- MISR chaining: after the first scenario, a second pattern with resp_in=16'h0001 gives sig=16'h5B6A.
- Backpressure:
  - Stimulus: so_ready low for 3 cycles on bit 5.
  - Required: so and so_valid stable through the stall; no bit lost or duplicated; done delayed by exactly 3 cycles.
- Settle boundary:
  - Stimulus: resp_in changes from 16'h0000 to 16'hFFFF at T+5.
  - Required: SETTLE=4 captures 16'hFFFF; SETTLE=0 captures the value present at T+1.
- Clear collision: sig_clr asserted in the CAPTURE cycle gives sig=0 afterwards, while the shifted response is still correct.
- Reset mid-shift:
  - Stimulus: rst asserted at bit 7.
  - Required: so_valid=0 and sig=0 immediately; no done; pat_ready=1 after release; a new pattern unloads normally.
